// File: rtl/multi_pulse_width_detector.sv
// Per-channel rise/fall detection and high-pulse width classification (short / ok / long).
// Define MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN to add the width_last capture output.

module mpwd_lane #(
  parameter int MIN_W = 1,
  parameter int MAX_W = 1,
  parameter int CW    = $clog2(MAX_W+2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_i,
  output logic          rise_o,
  output logic          fall_o,
  output logic          ok_o,
  output logic          short_o,
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
  output logic          long_o,
  output logic [CW-1:0] width_o
`else
  output logic          long_o
`endif
);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_W);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_W);
  localparam logic [CW-1:0] SAT_C = CW'(MAX_W + 1);

  logic          a_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rise_o  = a_i & ~a_q;
  assign fall_o  = ~a_i & a_q;
  assign ok_o    = fall_o & (cnt_q >= MIN_C) & (cnt_q <= MAX_C);
  assign short_o = fall_o & (cnt_q < MIN_C);
  assign long_o  = fall_o & (cnt_q == SAT_C);

  // Run length saturates one above MAX_W so "long" is remembered without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!a_i)              cnt_d = '0;
    else if (!a_q)         cnt_d = CW'(1);
    else if (cnt_q != SAT_C) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_i;
      cnt_q <= cnt_d;
    end
  end

`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
  logic [CW-1:0] width_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      width_q <= '0;
    else if (fall_o) width_q <= cnt_q;
  end

  assign width_o = width_q;
`endif
endmodule

module multi_pulse_width_detector #(
  parameter int N     = 4,
  parameter int MIN_W = 1,
  parameter int MAX_W = 1,
  parameter int CW    = $clog2(MAX_W+2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    a,
  output logic [N-1:0]    rise,
  output logic [N-1:0]    fall,
  output logic [N-1:0]    pulse_ok,
  output logic [N-1:0]    pulse_short,
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
  output logic [N-1:0]    pulse_long,
  output logic [N*CW-1:0] width_last
`else
  output logic [N-1:0]    pulse_long
`endif
);
  // One independent lane per channel; the instance array slices the buses per lane.
  mpwd_lane #(.MIN_W(MIN_W), .MAX_W(MAX_W), .CW(CW)) u_lane [N-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_i    (a),
    .rise_o (rise),
    .fall_o (fall),
    .ok_o   (pulse_ok),
    .short_o(pulse_short),
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    .long_o (pulse_long),
    .width_o(width_last)
`else
    .long_o (pulse_long)
`endif
  );
endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Directed bench: several detector configurations driven from hand-computed vectors.
module tb_multi_pulse_width_detector;
  logic clk, rst_n;
  int n_tests = 0, n_fail = 0;

  // A: N=1 MIN=MAX=1; B: N=2 MIN=2 MAX=3; C: N=4 MIN=MAX=1; D: N=1 MIN=1 MAX=5
  logic [0:0] a_a, rise_a, fall_a, ok_a, short_a, long_a;
  logic [1:0] a_b, rise_b, fall_b, ok_b, short_b, long_b;
  logic [3:0] a_c, rise_c, fall_c, ok_c, short_c, long_c;
  logic [0:0] a_d, rise_d, fall_d, ok_d, short_d, long_d;
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
  logic [1:0] wl_a;
  logic [5:0] wl_b;
  logic [7:0] wl_c;
  logic [2:0] wl_d;
`endif

  multi_pulse_width_detector #(.N(1), .MIN_W(1), .MAX_W(1)) u_a (
    .clk(clk), .rst_n(rst_n), .a(a_a), .rise(rise_a), .fall(fall_a),
    .pulse_ok(ok_a), .pulse_short(short_a),
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    .pulse_long(long_a), .width_last(wl_a)
`else
    .pulse_long(long_a)
`endif
  );
  multi_pulse_width_detector #(.N(2), .MIN_W(2), .MAX_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .a(a_b), .rise(rise_b), .fall(fall_b),
    .pulse_ok(ok_b), .pulse_short(short_b),
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    .pulse_long(long_b), .width_last(wl_b)
`else
    .pulse_long(long_b)
`endif
  );
  multi_pulse_width_detector #(.N(4), .MIN_W(1), .MAX_W(1)) u_c (
    .clk(clk), .rst_n(rst_n), .a(a_c), .rise(rise_c), .fall(fall_c),
    .pulse_ok(ok_c), .pulse_short(short_c),
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    .pulse_long(long_c), .width_last(wl_c)
`else
    .pulse_long(long_c)
`endif
  );
  multi_pulse_width_detector #(.N(1), .MIN_W(1), .MAX_W(5)) u_d (
    .clk(clk), .rst_n(rst_n), .a(a_d), .rise(rise_d), .fall(fall_d),
    .pulse_ok(ok_d), .pulse_short(short_d),
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    .pulse_long(long_d), .width_last(wl_d)
`else
    .pulse_long(long_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after negedge; checks land 2 time units later, well before posedge.
  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] A, R, OK, LG;
    logic [13:0] B0;
    int code [14];

    rst_n = 1'b0;
    a_a = '0; a_b = '0; a_c = '0; a_d = '0;
    #2;
    chk("rst_rise_c", rise_c, 0);
    chk("rst_fall_c", fall_c, 0);
    chk("rst_ok_c",   ok_c,   0);
    chk("rst_long_b", long_b, 0);
    chk("rst_short_b", short_b, 0);
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    chk("rst_width_d", wl_d, 0);
`endif
    a_a = 1'b1;
    #1;
    chk("rst_rise_comb", rise_a, 1);
    a_a = 1'b0;
    settle();
    rst_n = 1'b1;

    // One-cycle pulse detector equivalence, index 0 is first cycle (MSB)
    A  = 16'b1001011011110001;
    R  = 16'b1001010010000001;
    OK = 16'b0100100000000000;
    LG = 16'b0000000100001000;
    for (int i = 0; i < 16; i++) begin
      settle();
      a_a = A[15-i];
      #2;
      chk("t1_rise",  rise_a,  R[15-i]);
      chk("t1_ok",    ok_a,    OK[15-i]);
      chk("t1_long",  long_a,  LG[15-i]);
      chk("t1_short", short_a, 0);
      chk("t1_fall",  fall_a,  OK[15-i] | LG[15-i]);
    end
    settle();
    a_a = 1'b0;

    // Widths 1,2,3,4 against MIN=2 MAX=3; code 1=short 2=ok 3=long
    B0 = 14'b10110111011110;
    code = '{0, 1, 0, 0, 2, 0, 0, 0, 2, 0, 0, 0, 0, 3};
    for (int i = 0; i < 14; i++) begin
      settle();
      a_b = {1'b0, B0[13-i]};
      #2;
      chk("t2_short", short_b, {1'b0, code[i] == 1});
      chk("t2_ok",    ok_b,    {1'b0, code[i] == 2});
      chk("t2_long",  long_b,  {1'b0, code[i] == 3});
      chk("t2_ch1_rf", {rise_b[1], fall_b[1]}, 0);
    end

    // Saturation: 20-cycle high pulse
    for (int i = 0; i < 20; i++) begin
      settle();
      a_b = 2'b01;
      #2;
      if (i == 19) chk("sat_no_flag", {long_b, ok_b, short_b}, 0);
    end
    settle();
    a_b = 2'b00;
    #2;
    chk("sat_fall",  fall_b,  2'b01);
    chk("sat_long",  long_b,  2'b01);
    chk("sat_ok",    ok_b,    2'b00);
    chk("sat_short", short_b, 2'b00);
    settle();
    #2;
    chk("sat_long_once", long_b, 2'b00);
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    chk("sat_width", wl_b[2:0], 4);
`endif

    // Simultaneous events across four channels
    settle();
    a_c = 4'hF;
    #2;
    chk("sim_rise", rise_c, 4'hF);
    chk("sim_fall0", fall_c, 4'h0);
    settle();
    a_c = 4'h0;
    #2;
    chk("sim_fall", fall_c, 4'hF);
    chk("sim_ok",   ok_c,   4'hF);
    chk("sim_rise0", rise_c, 4'h0);
    chk("sim_long", long_c, 4'h0);
    settle();
    #2;
    chk("sim_quiet", {fall_c, ok_c}, 0);

    // Width capture: 3-cycle then 7-cycle pulses, MAX=5
    for (int i = 0; i < 3; i++) begin settle(); a_d = 1'b1; end
    settle();
    a_d = 1'b0;
    #2;
    chk("w_ok3", ok_d, 1);
    chk("w_long3", long_d, 0);
    settle();
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    #2;
    chk("w_width3", wl_d, 3);
`endif
    for (int i = 0; i < 7; i++) begin settle(); a_d = 1'b1; end
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    #2;
    chk("w_width_hold", wl_d, 3);
`endif
    settle();
    a_d = 1'b0;
    #2;
    chk("w_long7", long_d, 1);
    chk("w_ok7", ok_d, 0);
    settle();
`ifdef MULTI_PULSE_WIDTH_DETECTOR_WIDTH_OUT_EN
    #2;
    chk("w_width7", wl_d, 6);
`endif

    // Reset mid-pulse discards the pulse
    settle(); a_a = 1'b1;
    settle(); a_a = 1'b1;
    #2;
    rst_n = 1'b0;
    a_a = 1'b0;
    #1;
    chk("rmp_in_rst", {rise_a, fall_a, ok_a, short_a, long_a}, 0);
    #1;
    rst_n = 1'b1;
    settle();
    a_a = 1'b0;
    #2;
    chk("rmp_no_fall", fall_a, 0);
    chk("rmp_no_class", {ok_a, short_a, long_a}, 0);

    // Input held high through reset restarts the count at 1
    settle(); a_a = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rhi_rise_in_rst", rise_a, 1);
    #1;
    rst_n = 1'b1;
    settle();
    a_a = 1'b0;
    #2;
    chk("rhi_fall", fall_a, 1);
    chk("rhi_ok", ok_a, 1);
    chk("rhi_long", long_a, 0);

    settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
